// File: rtl/ht_encoder_param.sv
// Parametrised Huffman-tree encoder core.
// Loads NUM_SYM weights serially, performs one tree merge per clock, then streams every
// symbol's code MSB-first on out_code in ascending or descending symbol order.
// Optional feature macro HT_CODE_LEN_EN adds out_len, the code length on each code's first bit.
module ht_encoder_param #(
  parameter int unsigned NUM_SYM = 8,
  parameter int unsigned W_WIDTH = 3,
  parameter int unsigned SUM_W   = W_WIDTH + $clog2(NUM_SYM),
  parameter int unsigned LEN_W   = $clog2(NUM_SYM),
  localparam int unsigned LEN_OUT_W = LEN_W + (((32'd1 << LEN_W) == NUM_SYM) ? 1 : 0)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [W_WIDTH-1:0] in_weight,
  input  logic               out_mode,
  output logic               out_valid,
  output logic               out_code
`ifdef HT_CODE_LEN_EN
  ,
  output logic [LEN_OUT_W-1:0] out_len
`endif
);

  localparam int unsigned NUM_NODE = 2 * NUM_SYM - 1;
  localparam int unsigned IDX_W    = $clog2(NUM_NODE);
  localparam int unsigned CODE_W   = NUM_SYM - 1;

  typedef enum logic [1:0] {StIdle, StLoad, StMerge, StOut} state_e;
  state_e state_q, state_d;

  // Node table: leaves 0..NUM_SYM-1, merged nodes appended in creation order.
  logic [SUM_W-1:0]    node_w_q [NUM_NODE];
  logic [NUM_NODE-1:0] act_q;
  logic [NUM_SYM-1:0]  mask_q   [NUM_NODE];  // leaves covered by each node
  // Codes are kept right-aligned: a prepended bit lands at index len.
  logic [CODE_W-1:0]   code_q   [NUM_SYM];
  logic [LEN_W-1:0]    len_q    [NUM_SYM];
  logic [LEN_W-1:0]    cnt_q;   // load index, merge index or output symbol index
  logic [LEN_W-1:0]    bit_q;   // bits already sent of the current code
  logic                mode_q;

  logic [IDX_W-1:0] a_idx, b_idx, new_idx;
  logic [SUM_W-1:0] a_w, b_w;
  logic             a_found, b_found;
  logic [LEN_W-1:0] sym, cur_len, bit_idx;
  logic             last_load, last_merge, last_bit, last_sym;

  assign new_idx    = IDX_W'(NUM_SYM) + IDX_W'(cnt_q);
  assign last_load  = (cnt_q == LEN_W'(NUM_SYM - 1));
  assign last_merge = (cnt_q == LEN_W'(NUM_SYM - 2));
  assign sym        = mode_q ? (LEN_W'(NUM_SYM - 1) - cnt_q) : cnt_q;
  assign cur_len    = len_q[sym];
  assign bit_idx    = cur_len - LEN_W'(1) - bit_q;
  assign last_bit   = (bit_q == cur_len - LEN_W'(1));
  assign last_sym   = (cnt_q == LEN_W'(NUM_SYM - 1));

  // Two smallest active nodes; strict compare in ascending index order gives lower index on ties.
  always_comb begin
    a_idx   = '0;
    a_w     = '0;
    a_found = 1'b0;
    for (int i = 0; i < NUM_NODE; i++) begin
      if (act_q[i] && (!a_found || node_w_q[i] < a_w)) begin
        a_found = 1'b1;
        a_idx   = IDX_W'(i);
        a_w     = node_w_q[i];
      end
    end
    b_idx   = '0;
    b_w     = '0;
    b_found = 1'b0;
    for (int i = 0; i < NUM_NODE; i++) begin
      if (act_q[i] && (IDX_W'(i) != a_idx) && (!b_found || node_w_q[i] < b_w)) begin
        b_found = 1'b1;
        b_idx   = IDX_W'(i);
        b_w     = node_w_q[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StLoad;
      StLoad: begin
        if (!in_valid)     state_d = StIdle;
        else if (last_load) state_d = StMerge;
      end
      StMerge: if (last_merge) state_d = StOut;
      StOut:   if (last_bit && last_sym) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath: leaf capture, tree merges and output sequencing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_q  <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < NUM_NODE; i++) begin
        node_w_q[i] <= '0;
        mask_q[i]   <= '0;
      end
      for (int j = 0; j < NUM_SYM; j++) begin
        code_q[j] <= '0;
        len_q[j]  <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          bit_q <= '0;
          if (in_valid) begin
            // Start of frame: wipe the whole tree, then store leaf 0.
            mode_q <= out_mode;
            cnt_q  <= LEN_W'(1);
            act_q  <= NUM_NODE'(1);
            for (int i = 0; i < NUM_NODE; i++) begin
              node_w_q[i] <= '0;
              mask_q[i]   <= '0;
            end
            for (int j = 0; j < NUM_SYM; j++) begin
              code_q[j] <= '0;
              len_q[j]  <= '0;
            end
            node_w_q[0] <= SUM_W'(in_weight);
            mask_q[0]   <= NUM_SYM'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StLoad: begin
          if (in_valid) begin
            node_w_q[IDX_W'(cnt_q)] <= SUM_W'(in_weight);
            mask_q[IDX_W'(cnt_q)]   <= NUM_SYM'(1) << cnt_q;
            act_q[IDX_W'(cnt_q)]    <= 1'b1;
            cnt_q <= last_load ? '0 : cnt_q + LEN_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StMerge: begin
          node_w_q[new_idx] <= a_w + b_w;
          mask_q[new_idx]   <= mask_q[a_idx] | mask_q[b_idx];
          act_q[a_idx]      <= 1'b0;
          act_q[b_idx]      <= 1'b0;
          act_q[new_idx]    <= 1'b1;
          for (int j = 0; j < NUM_SYM; j++) begin
            if (mask_q[a_idx][j] || mask_q[b_idx][j]) begin
              code_q[j][len_q[j]] <= mask_q[b_idx][j];
              len_q[j]            <= len_q[j] + LEN_W'(1);
            end
          end
          cnt_q <= last_merge ? '0 : cnt_q + LEN_W'(1);
        end
        StOut: begin
          if (last_bit) begin
            bit_q <= '0;
            cnt_q <= last_sym ? '0 : cnt_q + LEN_W'(1);
          end else begin
            bit_q <= bit_q + LEN_W'(1);
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs are decoded from registered state; out_code is forced low outside OUT.
  always_comb begin
    out_valid = (state_q == StOut);
    out_code  = out_valid & code_q[sym][bit_idx];
`ifdef HT_CODE_LEN_EN
    out_len = (out_valid && bit_q == '0) ? LEN_OUT_W'(cur_len) : '0;
`endif
  end

endmodule

// File: doc/ht_encoder_param.md
Name: ht_encoder_param

Overview:
- Parametrised Huffman-tree encoder core; successor of the fixed 8-symbol, 3-bit-weight HT core that sits behind the chip I/O pads.
- Takes NUM_SYM symbol weights serially and builds the Huffman tree at one merge per clock.
- Streams the code of every symbol bit-serially on one output pin, in an order chosen by out_mode.

Parameters:
- NUM_SYM, 8, number of symbols (2..16).
- W_WIDTH, 3, bits per input weight.
- SUM_W, W_WIDTH+$clog2(NUM_SYM), width of node-weight accumulators.
- LEN_W, $clog2(NUM_SYM), width of code-length counters (max code length NUM_SYM-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  weight-input qualifier.
- in_weight  in  W_WIDTH  weight of current symbol; symbol index = input cycle count, starting at 0.
- out_mode  in  1  order select; sampled on first in_valid cycle only. 0 = ascending symbol index, 1 = descending.
- out_valid  out  1  high while out_code carries a code bit.
- out_code  out  1  serial code bit, root-first (MSB first).

Behaviour:
- Reset: synchronous on the clk edge with rst_n=0. out_valid=0, out_code=0, FSM=IDLE, all node/code state cleared. Reset mid-operation aborts everything; no further output.
- FSM: IDLE -> LOAD -> MERGE -> OUT -> IDLE.
- IDLE -> LOAD: in_valid=1 stores weight as leaf 0 and latches out_mode.
- LOAD: stores one leaf per in_valid cycle.
  - in_valid drop before NUM_SYM samples: discard the samples and return to IDLE.
  - After sample NUM_SYM-1: go to MERGE.
- MERGE: exactly NUM_SYM-1 cycles, one merge per cycle.
  - Among active nodes, pick the min-weight node A, then the next min B.
  - Ties: lower node index wins. Leaves are indices 0..NUM_SYM-1; merged nodes get NUM_SYM, NUM_SYM+1, ... in creation order.
  - New node weight = wA+wB at SUM_W bits; no overflow is possible.
  - A and B become inactive; the new node becomes active.
  - Every leaf under A gets bit 0 prepended to its code; every leaf under B gets bit 1 prepended. Prepend means the new bit becomes the MSB and length increments.
  - Zero weights are legal.
- OUT: emits the codes of all NUM_SYM symbols back-to-back with no gaps, each MSB first.
  - Order is symbol 0..NUM_SYM-1 when mode=0, NUM_SYM-1..0 when mode=1.
  - out_valid is held high for exactly the sum of code lengths; out_code=0 whenever out_valid=0.
- Latency: last in_valid at cycle T -> merges in T+1..T+NUM_SYM-1 -> first out_valid at T+NUM_SYM.
- in_valid asserted during MERGE/OUT is ignored. A new frame is accepted in the cycle after out_valid falls.
- Every code length is in 1..NUM_SYM-1.

Optional Feature:
- Macro: HT_CODE_LEN_EN.
- Defined: extra output out_len [LEN_W-1:0] (plus 1 bit when NUM_SYM is a power of 2). It carries the current symbol's code length on the first bit of each code and is 0 otherwise; reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Test Plan (NUM_SYM=8, W_WIDTH=3):
- Weights 1,1,1,1,1,1,1,1, mode 0 -> 24 bits: 000 001 010 011 100 101 110 111, out_valid high exactly 24 cycles starting 8 cycles after the last input.
- Weights 7,6,5,4,3,2,1,0, mode 0 -> 10 00 111 110 010 0111 01101 01100 (27 bits).
- Same weights, mode 1 -> 01100 01101 0111 010 110 111 00 10. With HT_CODE_LEN_EN, out_len pulses 5,5,4,3,3,3,2,2.
- All weights 0 -> identical to the all-ones case (exercises tie rule); in_valid pulsed during OUT -> ignored, no corruption.
- rst_n=0 for one cycle mid-OUT -> out_valid=0 next cycle, stays 0; a fresh frame afterwards gives correct codes.
- in_valid drops after 5 samples -> no output; the following full frame encodes correctly.
